flit_packetizer: RTL



---
 rtl/noc_flit_pkg.sv | 12 +
 rtl/flit_packetizer.sv | 82 ++++++++
 2 files changed

// File: rtl/noc_flit_pkg.sv
// Flit type encoding shared by the NoC packetizer and depacketizer.
package noc_flit_pkg;

  localparam int unsigned FlitTypeW = 2;

  typedef enum logic [FlitTypeW-1:0] {
    FlitBody = 2'b00,
    FlitHead = 2'b01,
    FlitTail = 2'b10
  } flit_type_e;

endpackage

// File: rtl/flit_packetizer.sv
// Turns a parallel packet (LEN payload words plus a destination id) into a
// HEAD, BODY..., TAIL flit stream with valid/ready flow control.
module flit_packetizer
  import noc_flit_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned LEN = 4,
  parameter int unsigned AW  = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DW*LEN-1:0]         pkt_din,
  input  logic [AW-1:0]             pkt_dst,
  input  logic                      pkt_valid_i,
  output logic                      pkt_ready_o,
  output logic [DW+FlitTypeW-1:0]   flit_dout,
  output logic                      flit_valid_o,
  input  logic                      flit_ready_i
);

  localparam int unsigned CntW  = $clog2(LEN + 1);
  localparam int unsigned FlitW = DW + FlitTypeW;
  localparam logic [CntW-1:0] LastIdx = CntW'(LEN - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [DW*LEN-1:0]  pay_q;
  logic [FlitW-1:0]   dout_q;
  logic               valid_q;

  logic [DW-1:0]      head_data;
  logic [DW-1:0]      next_word;
  flit_type_e         next_type;
  logic               is_tail;

  assign head_data = DW'(pkt_dst);
  // cnt_q indexes the payload word that the next flit transfer will load.
  assign next_word = pay_q[int'(cnt_q)*DW +: DW];
  assign next_type = (cnt_q == LastIdx) ? FlitTail : FlitBody;
  assign is_tail   = (dout_q[FlitW-1 -: FlitTypeW] == FlitTail);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pay_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pkt_valid_i) begin
            pay_q   <= pkt_din;
            dout_q  <= {FlitHead, head_data};
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (valid_q && flit_ready_i) begin
            if (is_tail) begin
              valid_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              dout_q <= {next_type, next_word};
              cnt_q  <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pkt_ready_o  = (state_q == StIdle);
  assign flit_dout    = dout_q;
  assign flit_valid_o = valid_q;

endmodule
